// File: rtl/defines.sv
// Shared decode definitions for the ALU issue stage: ALU operation enum, RV32I
// opcode/funct constants and the issue-register payload.
package defines;

   typedef enum logic [3:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_SLL,
      ALU_SLT,
      ALU_SLTU,
      ALU_XOR,
      ALU_SRL,
      ALU_SRA,
      ALU_OR,
      ALU_AND,
      ALU_COPY_1,
      ALU_COPY_2
   } alu_op_type;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_SLTU    = 3'b011;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   localparam logic [6:0] F7_BASE = 7'h00;
   localparam logic [6:0] F7_ALT  = 7'h20;

   typedef struct packed {
      logic [31:0] op1;
      logic [31:0] op2;
      alu_op_type  alu_type;
      logic [4:0]  rd_addr;
      logic        rd_we;
      logic        illegal;
   } issue_t;

   localparam issue_t ISSUE_RESET = '{
      op1:      32'd0,
      op2:      32'd0,
      alu_type: ALU_COPY_1,
      rd_addr:  5'd0,
      rd_we:    1'b0,
      illegal:  1'b0
   };

   // alt is instr[30] where it is meaningful (SUB / SRA), 0 otherwise.
   function automatic alu_op_type f3_to_op(input logic [2:0] f3, input logic alt);
      alu_op_type op;
      case (f3)
         F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
         F3_SLL:     op = ALU_SLL;
         F3_SLT:     op = ALU_SLT;
         F3_SLTU:    op = ALU_SLTU;
         F3_XOR:     op = ALU_XOR;
         F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
         F3_OR:      op = ALU_OR;
         default:    op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/imm_gen.sv
// RV32I immediate extraction: sign-extended I/S immediates and the U immediate.
module imm_gen (
   input  logic [31:0] instr,
   output logic [31:0] imm_i,
   output logic [31:0] imm_s,
   output logic [31:0] imm_u
);

   logic unused_opcode;

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_u = {instr[31:12], 12'd0};

   assign unused_opcode = ^instr[6:0];

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage: decodes an RV32I instruction into ALU operands/operation
// and holds it in a one-entry valid/ready register. Optional writeback bypass
// is enabled by defining ALU_ISSUE_BYPASS_EN.
module alu_issue_stage
   import defines::*;
#(
   parameter logic [31:0] RESET_PC_LINK = 32'd4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] instr,
   input  logic [31:0] pc,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   input  logic        wb_valid,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] op1,
   output logic [31:0] op2,
   output alu_op_type  alu_type,
   output logic [4:0]  rd_addr,
   output logic        rd_we,
   output logic        illegal
);

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] imm_i, imm_s, imm_u;
   logic [31:0] src1, src2;
   issue_t      dec, held;
   logic        wants_rd, is_illegal, load;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];

   imm_gen u_imm_gen (
      .instr (instr),
      .imm_i (imm_i),
      .imm_s (imm_s),
      .imm_u (imm_u)
   );

`ifdef ALU_ISSUE_BYPASS_EN
   assign src1 = (wb_valid && wb_rd != 5'd0 && wb_rd == instr[19:15]) ? wb_data : rs1_data;
   assign src2 = (wb_valid && wb_rd != 5'd0 && wb_rd == instr[24:20]) ? wb_data : rs2_data;
`else
   logic unused_wb;
   assign unused_wb = ^{wb_valid, wb_rd, wb_data};
   assign src1 = rs1_data;
   assign src2 = rs2_data;
`endif

   // NOTE: every field gets a default before the case so no path leaves a latch.
   always_comb begin
      dec          = ISSUE_RESET;
      dec.rd_addr  = instr[11:7];
      wants_rd     = 1'b0;
      is_illegal   = 1'b0;
      case (opcode)
         OPC_LUI: begin
            dec.alu_type = ALU_COPY_2;
            dec.op2      = imm_u;
            wants_rd     = 1'b1;
         end
         OPC_AUIPC: begin
            dec.alu_type = ALU_ADD;
            dec.op1      = pc;
            dec.op2      = imm_u;
            wants_rd     = 1'b1;
         end
         OPC_JAL, OPC_JALR: begin
            dec.alu_type = ALU_ADD;
            dec.op1      = pc;
            dec.op2      = RESET_PC_LINK;
            wants_rd     = 1'b1;
         end
         OPC_LOAD: begin
            dec.alu_type = ALU_ADD;
            dec.op1      = src1;
            dec.op2      = imm_i;
            wants_rd     = 1'b1;
         end
         OPC_STORE: begin
            dec.alu_type = ALU_ADD;
            dec.op1      = src1;
            dec.op2      = imm_s;
         end
         OPC_BRANCH: begin
            dec.alu_type = ALU_SUB;
            dec.op1      = src1;
            dec.op2      = src2;
         end
         OPC_OPIMM: begin
            dec.op1      = src1;
            dec.alu_type = f3_to_op(funct3, instr[30] && funct3 == F3_SRL_SRA);
            wants_rd     = 1'b1;
            // Shift-immediates carry a shamt plus a funct7 that must be checked.
            if (funct3 == F3_SLL || funct3 == F3_SRL_SRA) begin
               dec.op2    = {27'd0, instr[24:20]};
               is_illegal = !(funct7 == F7_BASE || (funct7 == F7_ALT && funct3 == F3_SRL_SRA));
            end else begin
               dec.op2    = imm_i;
            end
         end
         OPC_OP: begin
            dec.op1      = src1;
            dec.op2      = src2;
            dec.alu_type = f3_to_op(funct3, instr[30]);
            wants_rd     = 1'b1;
            is_illegal   = !(funct7 == F7_BASE ||
                             (funct7 == F7_ALT && (funct3 == F3_ADD_SUB || funct3 == F3_SRL_SRA)));
         end
         default: is_illegal = 1'b1;
      endcase

      if (is_illegal) begin
         dec.alu_type = ALU_COPY_1;
         dec.op1      = 32'd0;
         dec.op2      = 32'd0;
      end
      dec.illegal = is_illegal;
      dec.rd_we   = wants_rd && !is_illegal && (dec.rd_addr != 5'd0);
   end

   assign in_ready = !out_valid || out_ready;
   assign load     = in_valid && in_ready;

   // NOTE: state is updated with non-blocking assignments; rst is sampled on the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         held      <= ISSUE_RESET;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (load) begin
         out_valid <= 1'b1;
         held      <= dec;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   assign op1      = held.op1;
   assign op2      = held.op2;
   assign alu_type = held.alu_type;
   assign rd_addr  = held.rd_addr;
   assign rd_we    = held.rd_we;
   assign illegal  = held.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: table-driven decode vectors plus
// hand-written stall, flush, reset and bypass sequences.
module tb_alu_issue_stage;
   import defines::*;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready;
   logic [31:0] instr, pc, rs1_data, rs2_data;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        out_valid, out_ready;
   logic [31:0] op1, op2;
   alu_op_type  alu_type;
   logic [4:0]  rd_addr;
   logic        rd_we, illegal;

   int checks   = 0;
   int failures = 0;

   alu_issue_stage dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .instr     (instr),
      .pc        (pc),
      .rs1_data  (rs1_data),
      .rs2_data  (rs2_data),
      .wb_valid  (wb_valid),
      .wb_rd     (wb_rd),
      .wb_data   (wb_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .op1       (op1),
      .op2       (op2),
      .alu_type  (alu_type),
      .rd_addr   (rd_addr),
      .rd_we     (rd_we),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] instr, pc, rs1, rs2;
      logic [31:0] op1, op2;
      alu_op_type  alu;
      logic [4:0]  rd;
      logic        we, ill;
      bit          chk_op1, chk_op2, chk_rd;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input string name, input logic [31:0] i, p, a, b, e1, e2,
                               input alu_op_type alu, input logic [4:0] rd,
                               input logic we, ill, input bit c1, c2, cr);
      vec_t v;
      v.name = name; v.instr = i; v.pc = p; v.rs1 = a; v.rs2 = b;
      v.op1 = e1; v.op2 = e2; v.alu = alu; v.rd = rd; v.we = we; v.ill = ill;
      v.chk_op1 = c1; v.chk_op2 = c2; v.chk_rd = cr;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] i, p, a, b);
      instr = i; pc = p; rs1_data = a; rs2_data = b;
   endtask

   task automatic check_vec(input vec_t v);
      check({v.name, ".out_valid"}, 32'(out_valid), 32'd1);
      if (v.chk_op1) check({v.name, ".op1"}, op1, v.op1);
      if (v.chk_op2) check({v.name, ".op2"}, op2, v.op2);
      check({v.name, ".alu_type"}, 32'(alu_type), 32'(v.alu));
      if (v.chk_rd) check({v.name, ".rd_addr"}, 32'(rd_addr), 32'(v.rd));
      check({v.name, ".rd_we"}, 32'(rd_we), 32'(v.we));
      check({v.name, ".illegal"}, 32'(illegal), 32'(v.ill));
   endtask

   initial begin
      logic [31:0] exp_byp;

      //                name          instr         pc          rs1           rs2       op1           op2           alu        rd     we    ill  c1 c2 cr
      vecs.push_back(mk("add",        32'h002081B3, 32'h100, 32'd5,        32'd7, 32'd5,        32'd7,        ALU_ADD,    5'd3,  1'b1, 1'b0, 1, 1, 1));
      vecs.push_back(mk("sub_x0",     32'h40208033, 32'h104, 32'd5,        32'd7, 32'd5,        32'd7,        ALU_SUB,    5'd0,  1'b0, 1'b0, 1, 1, 1));
      vecs.push_back(mk("srai",       32'h4030D213, 32'h108, 32'h80000000, 32'd7, 32'h80000000, 32'd3,        ALU_SRA,    5'd4,  1'b1, 1'b0, 1, 1, 1));
      vecs.push_back(mk("addi_neg",   32'hFFF08293, 32'h10C, 32'd5,        32'd7, 32'd5,        32'hFFFFFFFF, ALU_ADD,    5'd5,  1'b1, 1'b0, 1, 1, 1));
      vecs.push_back(mk("lui",        32'h123453B7, 32'h110, 32'd5,        32'd7, 32'd0,        32'h12345000, ALU_COPY_2, 5'd7,  1'b1, 1'b0, 0, 1, 1));
      vecs.push_back(mk("auipc",      32'h00001417, 32'h200, 32'd5,        32'd7, 32'h200,      32'h1000,     ALU_ADD,    5'd8,  1'b1, 1'b0, 1, 1, 1));
      vecs.push_back(mk("jal",        32'h008000EF, 32'h300, 32'd5,        32'd7, 32'h300,      32'd4,        ALU_ADD,    5'd1,  1'b1, 1'b0, 1, 1, 1));
      vecs.push_back(mk("jalr_x0",    32'h00008067, 32'h304, 32'd5,        32'd7, 32'h304,      32'd4,        ALU_ADD,    5'd0,  1'b0, 1'b0, 1, 1, 1));
      vecs.push_back(mk("lw",         32'h00812303, 32'h308, 32'h1000,     32'd7, 32'h1000,     32'd8,        ALU_ADD,    5'd6,  1'b1, 1'b0, 1, 1, 1));
      vecs.push_back(mk("sw",         32'hFE512E23, 32'h30C, 32'h1000,     32'd7, 32'h1000,     32'hFFFFFFFC, ALU_ADD,    5'd0,  1'b0, 1'b0, 1, 1, 0));
      vecs.push_back(mk("beq",        32'h00208063, 32'h310, 32'd5,        32'd7, 32'd5,        32'd7,        ALU_SUB,    5'd0,  1'b0, 1'b0, 1, 1, 0));
      vecs.push_back(mk("slt",        32'h0020A4B3, 32'h314, 32'd5,        32'd7, 32'd5,        32'd7,        ALU_SLT,    5'd9,  1'b1, 1'b0, 1, 1, 1));
      vecs.push_back(mk("sra",        32'h4020D533, 32'h318, 32'd5,        32'd7, 32'd5,        32'd7,        ALU_SRA,    5'd10, 1'b1, 1'b0, 1, 1, 1));
      vecs.push_back(mk("xori",       32'h0F00C593, 32'h31C, 32'd9,        32'd7, 32'd9,        32'hF0,       ALU_XOR,    5'd11, 1'b1, 1'b0, 1, 1, 1));
      vecs.push_back(mk("slli31",     32'h01F09613, 32'h320, 32'd5,        32'd7, 32'd5,        32'd31,       ALU_SLL,    5'd12, 1'b1, 1'b0, 1, 1, 1));
      vecs.push_back(mk("andi",       32'hFFF0F713, 32'h324, 32'd5,        32'd7, 32'd5,        32'hFFFFFFFF, ALU_AND,    5'd14, 1'b1, 1'b0, 1, 1, 1));
      vecs.push_back(mk("ill_opc7f",  32'h0000007F, 32'h328, 32'd5,        32'd7, 32'd0,        32'd0,        ALU_COPY_1, 5'd0,  1'b0, 1'b1, 0, 0, 0));
      vecs.push_back(mk("ill_slli30", 32'h40109613, 32'h32C, 32'd5,        32'd7, 32'd0,        32'd0,        ALU_COPY_1, 5'd0,  1'b0, 1'b1, 0, 0, 0));
      vecs.push_back(mk("ill_xor30",  32'h4020C6B3, 32'h330, 32'd5,        32'd7, 32'd0,        32'd0,        ALU_COPY_1, 5'd0,  1'b0, 1'b1, 0, 0, 0));
      vecs.push_back(mk("ill_f7_01",  32'h022081B3, 32'h334, 32'd5,        32'd7, 32'd0,        32'd0,        ALU_COPY_1, 5'd0,  1'b0, 1'b1, 0, 0, 0));

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
      drive(32'h0, 32'h0, 32'h0, 32'h0);

      // Reset state after two reset cycles.
      tick(); tick();
      check("rst.out_valid", 32'(out_valid), 32'd0);
      check("rst.op1", op1, 32'd0);
      check("rst.op2", op2, 32'd0);
      check("rst.alu_type", 32'(alu_type), 32'(ALU_COPY_1));
      check("rst.rd_addr", 32'(rd_addr), 32'd0);
      check("rst.rd_we", 32'(rd_we), 32'd0);
      check("rst.illegal", 32'(illegal), 32'd0);
      check("rst.in_ready", 32'(in_ready), 32'd1);
      rst = 1'b0;

      // Back-to-back decode vectors at full throughput.
      in_valid = 1'b1;
      foreach (vecs[k]) begin
         drive(vecs[k].instr, vecs[k].pc, vecs[k].rs1, vecs[k].rs2);
         tick();
         check_vec(vecs[k]);
      end
      in_valid = 1'b0;
      tick();
      check("drain.out_valid", 32'(out_valid), 32'd0);

      // Backpressure: held entry must stay stable and the waiting one must not be lost.
      in_valid = 1'b1; out_ready = 1'b1;
      drive(32'h002081B3, 32'h400, 32'd5, 32'd7);
      tick();
      out_ready = 1'b0;
      drive(32'h0F00C593, 32'h404, 32'd9, 32'd0);
      #1;
      check("stall.in_ready_low", 32'(in_ready), 32'd0);
      for (int c = 0; c < 3; c++) begin
         tick();
         check("stall.out_valid", 32'(out_valid), 32'd1);
         check("stall.op1", op1, 32'd5);
         check("stall.op2", op2, 32'd7);
         check("stall.alu_type", 32'(alu_type), 32'(ALU_ADD));
         check("stall.rd_addr", 32'(rd_addr), 32'd3);
         check("stall.in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      #1;
      check("release.in_ready", 32'(in_ready), 32'd1);
      tick();
      check("release.out_valid", 32'(out_valid), 32'd1);
      check("release.op1", op1, 32'd9);
      check("release.op2", op2, 32'hF0);
      check("release.alu_type", 32'(alu_type), 32'(ALU_XOR));
      check("release.rd_addr", 32'(rd_addr), 32'd11);
      in_valid = 1'b0;
      tick();
      check("release.drained", 32'(out_valid), 32'd0);

      // Flush dominates an incoming instruction and drops the held one.
      in_valid = 1'b1;
      drive(32'h002081B3, 32'h500, 32'd5, 32'd7);
      tick();
      check("flush.pre_valid", 32'(out_valid), 32'd1);
      flush = 1'b1; out_ready = 1'b0;
      drive(32'h00108113, 32'h504, 32'd1, 32'd2);
      tick();
      check("flush.out_valid", 32'(out_valid), 32'd0);
      check("flush.in_ready", 32'(in_ready), 32'd1);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      tick();
      check("flush.nothing_loaded", 32'(out_valid), 32'd0);

      // Reset while an entry is stalled drops it.
      in_valid = 1'b1;
      drive(32'h002081B3, 32'h600, 32'd5, 32'd7);
      tick();
      in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
      tick();
      check("midrst.out_valid", 32'(out_valid), 32'd0);
      check("midrst.op1", op1, 32'd0);
      check("midrst.alu_type", 32'(alu_type), 32'(ALU_COPY_1));
      check("midrst.rd_we", 32'(rd_we), 32'd0);
      rst = 1'b0; out_ready = 1'b1;

      // Writeback bypass onto rs1 of ADDI x2,x1,1.
`ifdef ALU_ISSUE_BYPASS_EN
      exp_byp = 32'hAA;
`else
      exp_byp = 32'h11;
`endif
      in_valid = 1'b1;
      wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'hAA;
      drive(32'h00108113, 32'h700, 32'h11, 32'h22);
      tick();
      check("bypass.op1", op1, exp_byp);
      check("bypass.op2", op2, 32'd1);
      check("bypass.rd_we", 32'(rd_we), 32'd1);
      // x0 is never a bypass target.
      wb_rd = 5'd0;
      drive(32'h00100113, 32'h704, 32'h33, 32'h22);
      tick();
      check("bypass_x0.op1", op1, 32'h33);
      wb_valid = 1'b0; in_valid = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
